// File: rtl/mips16_pkg.sv
// Shared definitions for the MIPS16 sequential multiply/divide unit:
// op encodings, FSM state encoding and the iteration counter width.
package mips16_pkg;

   localparam int MULDIV_WIDTH = 16;
   localparam int MULDIV_CNT_W = $clog2(MULDIV_WIDTH) + 1;

   localparam logic MULDIV_MULTU = 1'b0;
   localparam logic MULDIV_DIVU  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

endpackage

// File: rtl/mips16_muldiv_step.sv
// One combinational iteration: shift-add for MULTU, restoring subtract-shift
// for DIVU. The divide path exists only when MIPS16_DIV_EN is defined.
module mips16_muldiv_step
   import mips16_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic             op_i,
   input  logic [WIDTH:0]   upper_i,
   input  logic [WIDTH-1:0] lower_i,
   input  logic [WIDTH-1:0] operand_i,
   output logic [WIDTH:0]   upper_o,
   output logic [WIDTH-1:0] lower_o
);

   logic [WIDTH:0] sum;
`ifdef MIPS16_DIV_EN
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;
`else
   logic unused_op;
   assign unused_op = op_i;
`endif

   always_comb begin
      // Multiply: {upper, lower} shifts right; the multiplier drains out of lower.
      sum     = upper_i + (lower_i[0] ? {1'b0, operand_i} : '0);
      upper_o = {1'b0, sum[WIDTH:1]};
      lower_o = {sum[0], lower_i[WIDTH-1:1]};
`ifdef MIPS16_DIV_EN
      // Divide: remainder in upper, dividend shifts out of lower as quotient shifts in.
      rem_sh = {upper_i[WIDTH-1:0], lower_i[WIDTH-1]};
      diff   = rem_sh - {1'b0, operand_i};
      if (op_i == MULDIV_DIVU) begin
         if (diff[WIDTH]) begin
            upper_o = rem_sh;
            lower_o = {lower_i[WIDTH-2:0], 1'b0};
         end else begin
            upper_o = diff;
            lower_o = {lower_i[WIDTH-2:0], 1'b1};
         end
      end
`endif
   end

endmodule

// File: rtl/mips16_muldiv_seq.sv
// Sequential MULTU/DIVU unit, one bit per RUN cycle, results in hi/lo.
// Divide support is built only when MIPS16_DIV_EN is defined.
module mips16_muldiv_seq
   import mips16_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             instr_stall_sl,
   output logic             ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   muldiv_state_e           state_q, state_d;
   logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;
   logic                    op_q, op_d;
   logic [WIDTH-1:0]        opnd_q, opnd_d;
   logic [WIDTH:0]          upper_q, upper_d;
   logic [WIDTH-1:0]        lower_q, lower_d;
   logic [WIDTH-1:0]        hi_q, hi_d;
   logic [WIDTH-1:0]        lo_q, lo_d;
   logic                    dz_q, dz_d;
   logic [WIDTH:0]          step_upper;
   logic [WIDTH-1:0]        step_lower;

   mips16_muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op_i      (op_q),
      .upper_i   (upper_q),
      .lower_i   (lower_q),
      .operand_i (opnd_q),
      .upper_o   (step_upper),
      .lower_o   (step_lower)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         op_q    <= 1'b0;
         opnd_q  <= '0;
         upper_q <= '0;
         lower_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dz_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         upper_q <= upper_d;
         lower_q <= lower_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      op_d           = op_q;
      opnd_d         = opnd_q;
      upper_d        = upper_q;
      lower_d        = lower_q;
      hi_d           = hi_q;
      lo_d           = lo_q;
      dz_d           = dz_q;
      instr_stall_sl = 1'b0;
      ready          = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               instr_stall_sl = 1'b1;
               op_d           = op;
               dz_d           = 1'b0;
               cnt_d          = '0;
               upper_d        = '0;
               if (op == MULDIV_MULTU) begin
                  state_d = ST_RUN;
                  opnd_d  = a;
                  lower_d = b;
               end else begin
`ifdef MIPS16_DIV_EN
                  if (b == '0) begin
                     state_d = ST_DONE;
                     hi_d    = a;
                     lo_d    = '1;
                     dz_d    = 1'b1;
                  end else begin
                     state_d = ST_RUN;
                     opnd_d  = b;
                     lower_d = a;
                  end
`else
                  state_d = ST_DONE;
                  dz_d    = 1'b1;
`endif
               end
            end
         end
         ST_RUN: begin
            instr_stall_sl = 1'b1;
            upper_d        = step_upper;
            lower_d        = step_lower;
            cnt_d          = cnt_q + 1'b1;
            // Both ops leave {hi, lo} in {upper[WIDTH-1:0], lower} after the last step.
            if (cnt_q == MULDIV_CNT_W'(WIDTH - 1)) begin
               state_d = ST_DONE;
               hi_d    = step_upper[WIDTH-1:0];
               lo_d    = step_lower;
            end
         end
         ST_DONE: begin
            ready   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_mips16_muldiv_seq.sv
// Self-checking bench for mips16_muldiv_seq: per-cycle reference model,
// result scoreboard, directed scenarios and randomized operations.
module tb_mips16_muldiv_seq;

   localparam int W = 16;

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         instr_stall_sl;
   logic         ready;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         div_zero;

   int checks = 0;
   int errors = 0;

   mips16_muldiv_seq #(.WIDTH(W)) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .op             (op),
      .a              (a),
      .b              (b),
      .instr_stall_sl (instr_stall_sl),
      .ready          (ready),
      .hi             (hi),
      .lo             (lo),
      .div_zero       (div_zero)
   );

   always #5 clock = ~clock;

   // Reference model state: cycles left in the operation, DONE flag, visible results.
   int             m_left   = 0;
   bit             m_done   = 1'b0;
   logic [W-1:0]   m_hi     = '0;
   logic [W-1:0]   m_lo     = '0;
   logic [W-1:0]   p_hi     = '0;
   logic [W-1:0]   p_lo     = '0;
   bit             m_dz     = 1'b0;
   int             accepts  = 0;
   int             aborted  = 0;
   int             readies  = 0;
   logic [2*W-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clock) begin
      if (!reset) begin
         if (m_done) begin
            m_done = 1'b0;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1;
               m_hi   = p_hi;
               m_lo   = p_lo;
            end
         end else if (start) begin
            accepts++;
            m_dz = 1'b0;
            if (op == 1'b0) begin
               {p_hi, p_lo} = 32'(a) * 32'(b);
               m_left = W;
            end
`ifdef MIPS16_DIV_EN
            else if (b == '0) begin
               m_done = 1'b1;
               m_hi   = a;
               m_lo   = '1;
               m_dz   = 1'b1;
            end else begin
               p_lo   = a / b;
               p_hi   = a % b;
               m_left = W;
            end
`else
            else begin
               m_done = 1'b1;
               m_dz   = 1'b1;
            end
`endif
            exp_q.push_back(m_done ? {m_hi, m_lo} : {p_hi, p_lo});
         end
      end
   end

   always @(negedge clock) begin
      if (reset) begin
         m_left = 0;
         m_done = 1'b0;
         m_hi   = '0;
         m_lo   = '0;
         m_dz   = 1'b0;
         aborted += exp_q.size();
         exp_q.delete();
      end
      check("stall", 32'(instr_stall_sl), 32'((m_left == 0 && !m_done && start) || m_left > 0));
      check("ready", 32'(ready), 32'(m_done));
      check("hi", 32'(hi), 32'(m_hi));
      check("lo", 32'(lo), 32'(m_lo));
      check("div_zero", 32'(div_zero), 32'(m_dz));
      if (ready === 1'b1) begin
         readies++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL result: got ready pulse with hi=%h lo=%h, expected no pending op", hi, lo);
         end else begin
            check("result", {hi, lo}, exp_q.pop_front());
         end
      end
   end

   // Called at posedge+2 of the accept cycle T; returns in the cycle after DONE.
   task automatic run_op(input logic o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input bit hold, output int lat, output int stall_n);
      int n;
      start = 1'b1;
      op    = o;
      a     = aa;
      b     = bb;
      @(negedge clock);
      stall_n = (instr_stall_sl === 1'b1) ? 1 : 0;
      @(posedge clock);
      #2;
      if (!hold) start = 1'b0;
      n = 1;
      while (n < 40) begin
         @(negedge clock);
         if (ready === 1'b1) break;
         if (instr_stall_sl === 1'b1) stall_n++;
         @(posedge clock);
         #2;
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got no ready within %0d cycles, expected one", n);
      end
      lat = n;
      @(posedge clock);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int stall_n;
      int acc0;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic ro;
      bit rh;

      reset = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      @(negedge clock);
      check("reset_hi", 32'(hi), 32'h0);
      check("reset_lo", 32'(lo), 32'h0);
      check("reset_ready", 32'(ready), 32'h0);
      check("reset_stall", 32'(instr_stall_sl), 32'h0);
      check("reset_div_zero", 32'(div_zero), 32'h0);
      idle(2);
      reset = 1'b0;
      idle(1);

      run_op(1'b0, 16'd7, 16'd9, 1'b0, lat, stall_n);
      check("mul7x9_latency", 32'(lat), 32'd17);
      check("mul7x9_stall_cycles", 32'(stall_n), 32'd17);
      check("mul7x9_hi", 32'(hi), 32'h0000);
      check("mul7x9_lo", 32'(lo), 32'h003F);

      run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, lat, stall_n);
      check("mulmax_hi", 32'(hi), 32'hFFFE);
      check("mulmax_lo", 32'(lo), 32'h0001);
      check("mulmax_div_zero", 32'(div_zero), 32'h0);

      run_op(1'b1, 16'd100, 16'd7, 1'b0, lat, stall_n);
`ifdef MIPS16_DIV_EN
      check("div100by7_latency", 32'(lat), 32'd17);
      check("div100by7_lo", 32'(lo), 32'h000E);
      check("div100by7_hi", 32'(hi), 32'h0002);
      check("div100by7_div_zero", 32'(div_zero), 32'h0);
`else
      check("div100by7_latency", 32'(lat), 32'd1);
      check("div100by7_hi_unchanged", 32'(hi), 32'hFFFE);
      check("div100by7_lo_unchanged", 32'(lo), 32'h0001);
      check("div100by7_div_zero", 32'(div_zero), 32'h1);
`endif

      run_op(1'b1, 16'h1234, 16'h0000, 1'b0, lat, stall_n);
      check("divzero_latency", 32'(lat), 32'd1);
      check("divzero_stall_cycles", 32'(stall_n), 32'd1);
      check("divzero_flag", 32'(div_zero), 32'h1);
`ifdef MIPS16_DIV_EN
      check("divzero_hi", 32'(hi), 32'h1234);
      check("divzero_lo", 32'(lo), 32'hFFFF);
`else
      check("divzero_hi_unchanged", 32'(hi), 32'hFFFE);
      check("divzero_lo_unchanged", 32'(lo), 32'h0001);
`endif
      idle(2);
      check("divzero_flag_holds", 32'(div_zero), 32'h1);

      // start held high across two back-to-back operations
      acc0 = accepts;
      run_op(1'b0, 16'd300, 16'd21, 1'b1, lat, stall_n);
      check("hold_first_latency", 32'(lat), 32'd17);
      run_op(1'b0, 16'd1000, 16'd1000, 1'b1, lat, stall_n);
      check("hold_second_latency", 32'(lat), 32'd17);
      check("hold_lo", 32'(lo), 32'h4240);
      check("hold_hi", 32'(hi), 32'h000F);
      start = 1'b0;
      idle(4);
      check("hold_accepts", 32'(accepts - acc0), 32'd2);

      // reset in the middle of a MULTU
      start = 1'b1;
      op    = 1'b0;
      a     = 16'hABCD;
      b     = 16'h1357;
      idle(1);
      start = 1'b0;
      idle(7);
      reset = 1'b1;
      @(negedge clock);
      check("midreset_hi", 32'(hi), 32'h0);
      check("midreset_lo", 32'(lo), 32'h0);
      check("midreset_ready", 32'(ready), 32'h0);
      check("midreset_stall", 32'(instr_stall_sl), 32'h0);
      idle(1);
      reset = 1'b0;
      idle(20);
      check("midreset_no_ready", 32'(readies), 32'(accepts - aborted));
      run_op(1'b0, 16'd3, 16'd5, 1'b0, lat, stall_n);
      check("after_reset_latency", 32'(lat), 32'd17);
      check("after_reset_lo", 32'(lo), 32'd15);

      for (int i = 0; i < 60; i++) begin
         ro = 1'($urandom_range(0, 1));
         ra = 16'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
         rh = ($urandom_range(0, 3) == 0);
         run_op(ro, ra, rb, rh, lat, stall_n);
         start = 1'b0;
         idle($urandom_range(0, 3));
      end

      idle(3);
      check("ready_count", 32'(readies), 32'(accepts - aborted));
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
